// File: rtl/qdiv_pkg.sv
// Shared definitions for the sequential signed-magnitude Q-format divider.
// Default word geometry and the FSM encoding shared with the multiplier-side control.
package qdiv_pkg;

    localparam int DEF_Q = 24;
    localparam int DEF_N = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } qdiv_state_t;

endpackage

// File: rtl/qdiv_step.sv
// One restoring radix-2 division step: shift a dividend bit into the partial
// remainder, trial-subtract the divisor magnitude, keep or restore.
module qdiv_step #(
    parameter int N = 32
) (
    input  logic [N-1:0] rem_in,
    input  logic         bit_in,
    input  logic [N-2:0] divisor,
    output logic [N-1:0] rem_out,
    output logic         q_bit
);

    logic [N:0] shifted;
    logic [N:0] diff;

    // The remainder stays below the divisor magnitude (< 2^(N-1)), so the
    // shifted value fits in N bits and diff[N] is a valid borrow flag.
    always_comb begin
        shifted = {rem_in, bit_in};
        diff    = shifted - {2'b00, divisor};
        q_bit   = ~diff[N];
        rem_out = q_bit ? diff[N-1:0] : shifted[N-1:0];
    end

endmodule

// File: rtl/qdiv_seq.sv
// Sequential signed-magnitude fixed-point divider (restoring, one quotient bit
// per clock). Result magnitude = floor((|a| << Q) / |b|), saturated on overflow;
// divide-by-zero short-circuits straight to DONE with a saturated result.
module qdiv_seq
    import qdiv_pkg::*;
#(
    parameter int Q = DEF_Q,
    parameter int N = DEF_N
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [N-1:0] i_dividend,
    input  logic [N-1:0] i_divisor,
    output logic         o_busy,
    output logic         o_done,
    output logic [N-1:0] o_quotient,
    output logic         o_ovr
);

    localparam int ITER  = N - 1 + Q;
    localparam int CNT_W = $clog2(ITER + 1);

    qdiv_state_t state_q, state_d;

    logic [CNT_W-1:0] cnt_q;
    logic [ITER-1:0]  shreg_q;
    logic [ITER-1:0]  quot_q;
    logic [ITER-1:0]  quot_nxt;
    logic [N-1:0]     rem_q;
    logic [N-1:0]     rem_nxt;
    logic [N-2:0]     div_mag_q;
    logic             sign_q;
    logic             q_bit;

    logic             accept;
    logic             div_zero;
    logic             sign_new;
    logic             last_step;

    // Quotient bits above the magnitude field mean the result cannot be represented.
    function automatic logic quot_ovf(input logic [ITER-1:0] q);
        return |q[ITER-1:N-1];
    endfunction

    // Saturate an ITER-bit quotient into the N-1 bit magnitude field.
    function automatic logic [N-2:0] sat_mag(input logic [ITER-1:0] q);
        return quot_ovf(q) ? {(N-1){1'b1}} : q[N-2:0];
    endfunction

    assign accept    = (state_q == ST_IDLE) && i_start;
    assign div_zero  = (i_divisor[N-2:0] == '0);
    assign sign_new  = i_dividend[N-1] ^ i_divisor[N-1];
    assign last_step = (state_q == ST_CALC) && (cnt_q == CNT_W'(ITER - 1));
    assign quot_nxt  = {quot_q[ITER-2:0], q_bit};

    assign o_busy = (state_q == ST_CALC);
    assign o_done = (state_q == ST_DONE);

    qdiv_step #(
        .N(N)
    ) u_step (
        .rem_in  (rem_q),
        .bit_in  (shreg_q[ITER-1]),
        .divisor (div_mag_q),
        .rem_out (rem_nxt),
        .q_bit   (q_bit)
    );

    // Next-state logic: a zero divisor bypasses the iteration entirely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = div_zero ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (last_step) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state, iteration counter and the held result outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            o_quotient <= '0;
            o_ovr      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q <= '0;
                if (div_zero) begin
                    o_quotient <= {sign_new, {(N-1){1'b1}}};
                    o_ovr      <= 1'b1;
                end
            end else if (state_q == ST_CALC) begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (last_step) begin
                    o_quotient <= {sign_q, sat_mag(quot_nxt)};
                    o_ovr      <= quot_ovf(quot_nxt);
                end
            end
        end
    end

    // Datapath: operand capture on accept, then one restoring step per CALC cycle.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            shreg_q   <= {i_dividend[N-2:0], {Q{1'b0}}};
            rem_q     <= '0;
            quot_q    <= '0;
            div_mag_q <= i_divisor[N-2:0];
            sign_q    <= sign_new;
        end else if (state_q == ST_CALC) begin
            shreg_q <= {shreg_q[ITER-2:0], 1'b0};
            rem_q   <= rem_nxt;
            quot_q  <= quot_nxt;
        end
    end

endmodule
